dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_pkg.sv | 24 ++
 rtl/rr_select.sv | 32 +++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared parameters and types for the shared-memory arbiter.
// Holds the size defaults, the memory read latency and the issue-stage op encoding.
`timescale 1ns/1ps
package dm_pkg;

    localparam int NCORE_DEF  = 4;
    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 16;
    localparam int CW_DEF     = 16;

    // Cycles from the memory address being presented to mem_rdata being valid.
    localparam int MEM_RD_LAT = 1;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: the first requesting index at or after ptr wins, wrapping at N-1.
// Purely combinational; produces a one-hot grant, its index and an any-grant flag.
`timescale 1ns/1ps
module rr_select #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving NCORE cores access to one synchronous-read memory.
// Grant (comb) -> issue stage (registered address/data) -> return stage (rvalid, rdata).
`timescale 1ns/1ps
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int NCORE = NCORE_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCORE-1:0]    req,
    input  logic [NCORE-1:0]    we,
    input  logic [NCORE*AW-1:0] addr,
    input  logic [NCORE*DW-1:0] wdata,
    output logic [NCORE-1:0]    gnt,
    output logic [NCORE-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic [DW-1:0]       to_mem,
    input  logic                cnt_clr,
    output logic [NCORE*CW-1:0] cnt
);

    localparam int PW = ptr_width(NCORE);

    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;

    op_e              issue_op_reg;
    logic [NCORE-1:0] issue_sel_reg;
    logic [AW-1:0]    mem_addr_reg;
    logic [DW-1:0]    mem_wdata_reg;
    logic [DW-1:0]    to_mem_reg;
    logic [DW-1:0]    rdata_reg;
    logic [NCORE-1:0] rd_pipe_reg [MEM_RD_LAT];

    rr_select #(
        .N  (NCORE),
        .PW (PW)
    ) u_rr_select (
        .req (req),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (gnt_any) begin
            ptr_reg <= (gnt_idx == PW'(NCORE - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Issue stage: address and write data are captured for every grant and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_op_reg  <= OP_NONE;
            issue_sel_reg <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (gnt_any) begin
            issue_op_reg  <= we[gnt_idx] ? OP_WRITE : OP_READ;
            issue_sel_reg <= gnt;
            mem_addr_reg  <= addr[gnt_idx*AW +: AW];
            mem_wdata_reg <= wdata[gnt_idx*DW +: DW];
        end else begin
            issue_op_reg  <= OP_NONE;
        end
    end

    assign mem_we    = (issue_op_reg == OP_WRITE);
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Return pipeline carries the one-hot owner of each read while memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                rd_pipe_reg[i] <= '0;
            end
        end else begin
            rd_pipe_reg[0] <= (issue_op_reg == OP_READ) ? issue_sel_reg : '0;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                rd_pipe_reg[i] <= rd_pipe_reg[i-1];
            end
        end
    end

    assign rvalid = rd_pipe_reg[MEM_RD_LAT-1];

    // Memory data is live only in its valid cycle, so rdata passes it through then holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg  <= '0;
            to_mem_reg <= '0;
        end else begin
            if (|rvalid) begin
                rdata_reg <= mem_rdata;
            end
            if (mem_we) begin
                to_mem_reg <= mem_wdata_reg;
            end
        end
    end

    assign rdata  = (|rvalid) ? mem_rdata : rdata_reg;
    assign to_mem = to_mem_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCORE; gi++) begin : g_cnt
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (gnt[gi] && (cnt_reg != {CW{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt[gi*CW +: CW] = cnt_reg;
        end
    endgenerate

endmodule
